// File: rtl/tick_seq_pkg.sv
// tick_seq_pkg -- shared constants for the tick sequencer.
//   ST_IDLE / ST_RUN / ST_DONE : sequencer state encoding (0 / 1 / 2)
//   STEPS_DEFAULT              : default number of sequence table entries
//   RPT_W                      : width of the per-entry repeat count
package tick_seq_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  localparam int STEPS_DEFAULT = 4;
  localparam int RPT_W         = 8;

endpackage

// File: rtl/tick_sequencer_period_counter.sv
// period_counter -- divide-by-(M+1) counter with square-ish output.
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   en     : count enable (high while the sequencer runs)
//   clr    : synchronous clear of the count, wins over en
//   m      : divide value M; period is M+1 cycles
//   q      : 0 while cnt < M/2, 1 otherwise; 0 when not enabled
//   tick   : 1 in the cycle where cnt == M while enabled
module period_counter #(
  parameter int N = 24
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         clr,
  input  logic [N-1:0] m,
  output logic         q,
  output logic         tick
);

  logic [N-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= (cnt == m) ? '0 : cnt + N'(1);
    end
  end

  // With M=0 the count sits at 0 and 0 >= 0, so q stays 1 and every cycle ticks.
  assign q    = en && (cnt >= (m >> 1));
  assign tick = en && (cnt == m);

endmodule

// File: rtl/tick_sequencer.sv
// tick_sequencer -- steps through a table of (divide M, repeat count) entries,
// producing a divided clock q and a tick pulse at every period end.
//   clk      : clock, rising edge
//   reset    : asynchronous active-low reset; clears FSM and the whole table
//   start    : begin the sequence at step 0 (from IDLE or DONE)
//   stop     : abort to IDLE (from RUN or DONE); beats start in the same cycle
//   cfg_wr   : table write strobe, honoured only outside RUN
//   cfg_addr : table entry index
//   cfg_div  : divide value M for the entry
//   cfg_rpt  : number of periods for the entry (0 behaves as 1)
//   q        : divided output, 0 outside RUN
//   tick     : one-cycle pulse at each period end
//   step     : active table entry
//   busy     : high in RUN
//   done     : high in DONE
// Build option: define TICK_SEQ_LOOP_EN to wrap from the last step back to
// step 0 instead of finishing in DONE.
// Handshake: start/stop/cfg_wr are level-sampled single-cycle strobes; each is
// acted on at the rising edge where it is high, no acknowledge is returned.
module tick_sequencer
  import tick_seq_pkg::*;
#(
  parameter int N     = 24,
  parameter int STEPS = STEPS_DEFAULT,
  localparam int AW   = (STEPS > 1) ? $clog2(STEPS) : 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stop,
  input  logic             cfg_wr,
  input  logic [AW-1:0]    cfg_addr,
  input  logic [N-1:0]     cfg_div,
  input  logic [RPT_W-1:0] cfg_rpt,
  output logic             q,
  output logic             tick,
  output logic [AW-1:0]    step,
  output logic             busy,
  output logic             done
);

  localparam logic [AW-1:0] LAST_STEP = AW'(STEPS - 1);

  logic [N-1:0]     div_tab [STEPS];
  logic [RPT_W-1:0] rpt_tab [STEPS];

  logic [1:0]       state, state_n;
  logic [AW-1:0]    step_n;
  logic [RPT_W-1:0] pcount, pcount_n;
  logic             clr;
  logic [RPT_W-1:0] eff_rpt;
  logic [RPT_W:0]   pcount_inc;
  logic             last_period;

  // Table: cleared by reset, writable only while the sequence is not running.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < STEPS; i++) begin
        div_tab[i] <= '0;
        rpt_tab[i] <= '0;
      end
    end else if (cfg_wr && (state != ST_RUN)) begin
      div_tab[cfg_addr] <= cfg_div;
      rpt_tab[cfg_addr] <= cfg_rpt;
    end
  end

  // A repeat count of 0 runs one period, same as 1.
  assign eff_rpt     = (rpt_tab[step] == '0) ? RPT_W'(1) : rpt_tab[step];
  assign pcount_inc  = {1'b0, pcount} + {{RPT_W{1'b0}}, 1'b1};
  assign last_period = (pcount_inc >= {1'b0, eff_rpt});

  always_comb begin
    state_n  = state;
    step_n   = step;
    pcount_n = pcount;
    // Holding the counter cleared outside RUN guarantees cnt=0 on RUN entry.
    clr      = (state != ST_RUN);
    case (state)
      ST_IDLE, ST_DONE: begin
        if (stop) begin
          state_n  = ST_IDLE;
          step_n   = '0;
          pcount_n = '0;
        end else if (start) begin
          state_n  = ST_RUN;
          step_n   = '0;
          pcount_n = '0;
        end
      end
      ST_RUN: begin
        if (stop) begin
          state_n  = ST_IDLE;
          step_n   = '0;
          pcount_n = '0;
          clr      = 1'b1;
        end else if (tick) begin
          if (last_period) begin
            pcount_n = '0;
            clr      = 1'b1;
            if (step == LAST_STEP) begin
`ifdef TICK_SEQ_LOOP_EN
              step_n = '0;
`else
              state_n = ST_DONE;
`endif
            end else begin
              step_n = step + AW'(1);
            end
          end else begin
            pcount_n = pcount + RPT_W'(1);
          end
        end
      end
      default: begin
        state_n  = ST_IDLE;
        step_n   = '0;
        pcount_n = '0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= ST_IDLE;
      step   <= '0;
      pcount <= '0;
    end else begin
      state  <= state_n;
      step   <= step_n;
      pcount <= pcount_n;
    end
  end

  assign busy = (state == ST_RUN);
  assign done = (state == ST_DONE);

  period_counter #(.N(N)) u_period_counter (
    .clk   (clk),
    .reset (reset),
    .en    (busy),
    .clr   (clr),
    .m     (div_tab[step]),
    .q     (q),
    .tick  (tick)
  );

endmodule

// File: tb/tb_tick_sequencer.sv
// tb_tick_sequencer -- directed bench for tick_sequencer (N=24, STEPS=4).
// Expected values are hand-derived from the period/repeat rules; with
// TICK_SEQ_LOOP_EN defined the end-of-sequence expectations switch to wrap.
module tb_tick_sequencer;

  logic        clk;
  logic        reset;
  logic        start;
  logic        stop;
  logic        cfg_wr;
  logic [1:0]  cfg_addr;
  logic [23:0] cfg_div;
  logic [7:0]  cfg_rpt;
  logic        q;
  logic        tick;
  logic [1:0]  step;
  logic        busy;
  logic        done;

  int n_tests = 0;
  int n_fail  = 0;

  logic [19:0] qv;
  logic [19:0] tv;

  tick_sequencer #(.N(24), .STEPS(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .stop     (stop),
    .cfg_wr   (cfg_wr),
    .cfg_addr (cfg_addr),
    .cfg_div  (cfg_div),
    .cfg_rpt  (cfg_rpt),
    .q        (q),
    .tick     (tick),
    .step     (step),
    .busy     (busy),
    .done     (done)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver tasks: every action ends 1 time unit after a rising edge.
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic cfg_write(input logic [1:0] a, input logic [23:0] d, input logic [7:0] r);
    cfg_wr   = 1'b1;
    cfg_addr = a;
    cfg_div  = d;
    cfg_rpt  = r;
    cyc(1);
    cfg_wr   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    cyc(1);
    start = 1'b0;
  endtask

  task automatic pulse_stop();
    stop = 1'b1;
    cyc(1);
    stop = 1'b0;
  endtask

  task automatic program_base();
    cfg_write(2'd0, 24'd9, 8'd2);
    cfg_write(2'd1, 24'd3, 8'd1);
    cfg_write(2'd2, 24'd3, 8'd1);
    cfg_write(2'd3, 24'd3, 8'd1);
  endtask

  // Scoreboard check
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset    = 1'b0;
    start    = 1'b0;
    stop     = 1'b0;
    cfg_wr   = 1'b0;
    cfg_addr = '0;
    cfg_div  = '0;
    cfg_rpt  = '0;
    #1;
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_q",    32'(q),    32'd0);
    chk("rst_tick", 32'(tick), 32'd0);
    chk("rst_step", 32'(step), 32'd0);
    cyc(2);
    reset = 1'b1;
    cyc(1);

    // Base sequence: entry 0 M=9 rpt=2, entries 1-3 M=3 rpt=1.
    program_base();
    pulse_start();
    for (int i = 0; i < 20; i++) begin
      qv[i] = q;
      tv[i] = tick;
      cyc(1);
    end
    chk("base_q_e0",    32'(qv), 32'h000FC3F0);
    chk("base_tick_e0", 32'(tv), 32'h00080200);
    chk("base_step1",   32'(step), 32'd1);
    chk("base_busy",    32'(busy), 32'd1);
    for (int i = 0; i < 12; i++) begin
      qv[i] = q;
      tv[i] = tick;
      if (i == 4) chk("base_step2", 32'(step), 32'd2);
      cyc(1);
    end
    chk("base_q_e123",    32'(qv[11:0]), 32'h00000EEE);
    chk("base_tick_e123", 32'(tv[11:0]), 32'h00000888);
`ifdef TICK_SEQ_LOOP_EN
    chk("end_step", 32'(step), 32'd0);
    chk("end_busy", 32'(busy), 32'd1);
    chk("end_done", 32'(done), 32'd0);
    cyc(20);
    chk("loop_again_step", 32'(step), 32'd1);
    chk("loop_done_low",   32'(done), 32'd0);
`else
    chk("end_step", 32'(step), 32'd3);
    chk("end_busy", 32'(busy), 32'd0);
    chk("end_done", 32'(done), 32'd1);
    chk("end_q",    32'(q),    32'd0);
    chk("end_tick", 32'(tick), 32'd0);
`endif

    // Stop from DONE (or RUN when looping) returns to IDLE.
    pulse_stop();
    chk("stop1_busy", 32'(busy), 32'd0);
    chk("stop1_done", 32'(done), 32'd0);
    chk("stop1_step", 32'(step), 32'd0);

    // Stop during step 1 at cnt=2.
    pulse_start();
    cyc(22);
    chk("mid_step", 32'(step), 32'd1);
    chk("mid_q",    32'(q),    32'd1);
    pulse_stop();
    chk("stop2_busy", 32'(busy), 32'd0);
    chk("stop2_q",    32'(q),    32'd0);
    chk("stop2_step", 32'(step), 32'd0);
    pulse_start();
    chk("restart_busy", 32'(busy), 32'd1);
    chk("restart_step", 32'(step), 32'd0);
    chk("restart_q",    32'(q),    32'd0);
    cyc(9);
    chk("restart_tick9", 32'(tick), 32'd1);
    chk("restart_step9", 32'(step), 32'd0);
    pulse_stop();

    // start and stop together in IDLE: stop wins.
    start = 1'b1;
    stop  = 1'b1;
    cyc(1);
    start = 1'b0;
    stop  = 1'b0;
    chk("both_busy", 32'(busy), 32'd0);
    chk("both_done", 32'(done), 32'd0);

    // Writes during RUN are ignored.
    pulse_start();
    cfg_write(2'd0, 24'd0, 8'd0);
    cfg_write(2'd1, 24'd0, 8'd0);
    pulse_stop();
    pulse_start();
    chk("wr_run_tick0", 32'(tick), 32'd0);
    cyc(8);
    chk("wr_run_tick8", 32'(tick), 32'd0);
    cyc(1);
    chk("wr_run_tick9", 32'(tick), 32'd1);
    pulse_stop();

    // All entries M=0 rpt=0: four consecutive tick cycles, then the end.
    for (int a = 0; a < 4; a++) cfg_write(2'(a), 24'd0, 8'd0);
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      qv[i] = q;
      tv[i] = tick;
      if (i == 3) chk("m0_step3", 32'(step), 32'd3);
      cyc(1);
    end
    chk("m0_tick", 32'(tv[3:0]), 32'h0000000F);
    chk("m0_q",    32'(qv[3:0]), 32'h0000000F);
`ifdef TICK_SEQ_LOOP_EN
    chk("m0_end_step", 32'(step), 32'd0);
    chk("m0_end_busy", 32'(busy), 32'd1);
`else
    chk("m0_end_done", 32'(done), 32'd1);
    chk("m0_end_tick", 32'(tick), 32'd0);
`endif
    pulse_stop();

    // Asynchronous reset mid-RUN, then confirm the table was cleared.
    program_base();
    pulse_start();
    cyc(5);
    chk("pre_rst_q",    32'(q),    32'd1);
    chk("pre_rst_busy", 32'(busy), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_busy", 32'(busy), 32'd0);
    chk("arst_q",    32'(q),    32'd0);
    chk("arst_tick", 32'(tick), 32'd0);
    chk("arst_step", 32'(step), 32'd0);
    chk("arst_done", 32'(done), 32'd0);
    reset = 1'b1;
    pulse_start();
    for (int i = 0; i < 4; i++) begin
      tv[i] = tick;
      cyc(1);
    end
    chk("arst_table_tick", 32'(tv[3:0]), 32'h0000000F);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/tick_sequencer.md
TICK_SEQUENCER -- requirements
Module: tick_sequencer

Interface
REQ-001 The block SHALL have parameter N, default 24, giving the width of the period counter and the divide values.
REQ-002 The block SHALL have parameter STEPS, default 4, giving the number of sequence table entries.
REQ-003 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have port start, input, 1 bit: begin sequence from step 0.
REQ-006 The block SHALL have port stop, input, 1 bit: abort sequence.
REQ-007 The block SHALL have port cfg_wr, input, 1 bit: table write strobe.
REQ-008 The block SHALL have port cfg_addr, input, clog2(STEPS) bits: table entry index.
REQ-009 The block SHALL have port cfg_div, input, N bits: divide value M for the entry.
REQ-010 The block SHALL have port cfg_rpt, input, 8 bits: number of periods for the entry.
REQ-011 The block SHALL have port q, output, 1 bit: divided output.
REQ-012 The block SHALL have port tick, output, 1 bit: one-cycle pulse at each period end.
REQ-013 The block SHALL have port step, output, clog2(STEPS) bits: active entry index.
REQ-014 The block SHALL have ports busy and done, output, 1 bit each: state flags.

Function
REQ-015 The FSM SHALL have states IDLE, RUN and DONE.
REQ-016 In IDLE and DONE, cfg_wr=1 SHALL write cfg_div and cfg_rpt to entry cfg_addr; writes in RUN SHALL be ignored.
REQ-017 start=1 in IDLE or DONE SHALL enter RUN next cycle with step=0, cnt=0 and period count 0.
REQ-018 In RUN, cnt SHALL be 0 when cnt==M, else cnt+1, giving a period of M+1 cycles.
REQ-019 In RUN, q SHALL be 0 while cnt<M/2 (integer division) and 1 otherwise; q SHALL be 0 outside RUN.
REQ-020 tick SHALL be 1 for exactly the cycle in which cnt==M in RUN.
REQ-021 At each tick the period count SHALL increment; when it reaches the entry's rpt, step SHALL advance and cnt and the period count SHALL clear on the same edge.
REQ-022 rpt=0 SHALL be treated as 1.
REQ-023 An entry with M=0 SHALL produce one tick cycle per period, with q=1.
REQ-024 Leaving the last step SHALL enter DONE, with step held at STEPS-1.
REQ-025 stop=1 in RUN or DONE SHALL enter IDLE next cycle and clear cnt, step and the period count.
REQ-026 If start and stop are both 1 in the same cycle, stop SHALL win.
REQ-027 busy SHALL be 1 only in RUN, and done SHALL be 1 only in DONE.

Reset
REQ-028 reset=0 SHALL immediately force IDLE with cnt=0, step=0, period count 0, q=0, tick=0, busy=0 and done=0, including mid-sequence.
REQ-029 reset=0 SHALL clear all table entries to M=0 and rpt=0.

Configuration
REQ-030 With macro TICK_SEQ_LOOP_EN defined, leaving the last step SHALL wrap to step 0 and stay in RUN, with done never set.
REQ-031 Without TICK_SEQ_LOOP_EN, leaving the last step SHALL enter DONE as in REQ-024.

Structure
REQ-032 Shared package tick_seq_pkg SHALL hold the state encoding (IDLE=0, RUN=1, DONE=2), the default STEPS and the rpt width constant.
REQ-033 The cnt/q/tick logic SHALL be a sub-module named period_counter, with a synchronous clear input and an N-bit M input.

Verification
REQ-034 Program entry 0 with M=9, rpt=2, and entries 1-3 with M=3, rpt=1, then start -> q low 4 cycles and high 6 cycles twice, ticks at cycles 10 and 20, step=1 after cycle 20, done after 32 cycles.
REQ-035 Pulse stop during step 1, cnt=2 -> next cycle busy=0, q=0, step=0, and a subsequent start restarts at step 0.
REQ-036 Program all entries with M=0, rpt=0, then start -> tick high on 4 consecutive cycles, then done.
REQ-037 Assert reset=0 mid-RUN asynchronously -> outputs clear before the next clk edge, and the table reads back as zero.
REQ-038 Assert start and stop together in IDLE -> state stays IDLE; cfg_wr during RUN -> the table is unchanged.
REQ-039 With TICK_SEQ_LOOP_EN defined, run the REQ-034 sequence -> step wraps 3->0 at cycle 32, busy stays 1, done stays 0.
